// File: rtl/issue_scoreboard_pkg.sv
// Shared types and constants for the issue scoreboard slice.
package issue_scoreboard_pkg;

    localparam int unsigned REG_AW           = 5;
    localparam int unsigned FLAG_W           = 4;
    localparam int unsigned INFL_W           = 3;
    localparam int unsigned MAX_INFLIGHT_DEF = 4;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } sb_state_e;

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode/writeback/flush bundle between the front end and the issue scoreboard.
interface issue_scoreboard_if;
    import issue_scoreboard_pkg::*;

    logic              dec_valid;
    logic              dec_ready;
    logic [REG_AW-1:0] dec_src1;
    logic [REG_AW-1:0] dec_src2;
    logic              dec_use1;
    logic              dec_use2;
    logic [REG_AW-1:0] dec_dst1;
    logic [REG_AW-1:0] dec_dst2;
    logic              dec_wr1;
    logic              dec_wr2;
    logic              dec_is_cond;
    logic [FLAG_W-1:0] dec_wr_flags;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_a1;
    logic [REG_AW-1:0] wb_a2;
    logic              wb_we1;
    logic              wb_we2;
    logic              wb_flags;
    logic              flush;
    logic              ex_issue;

    modport master (
        output dec_valid, dec_src1, dec_src2, dec_use1, dec_use2,
               dec_dst1, dec_dst2, dec_wr1, dec_wr2, dec_is_cond, dec_wr_flags,
               wb_valid, wb_a1, wb_a2, wb_we1, wb_we2, wb_flags, flush,
        input  dec_ready, ex_issue
    );

    modport slave (
        input  dec_valid, dec_src1, dec_src2, dec_use1, dec_use2,
               dec_dst1, dec_dst2, dec_wr1, dec_wr2, dec_is_cond, dec_wr_flags,
               wb_valid, wb_a1, wb_a2, wb_we1, wb_we2, wb_flags, flush,
        output dec_ready, ex_issue
    );

endinterface

// File: rtl/issue_scoreboard_sb_hazard_check.sv
// Combinational RAW/WAW/flag hazard evaluation against a view of the scoreboard.
module sb_hazard_check
    import issue_scoreboard_pkg::*;
#(
    parameter int unsigned NREGS = 32
) (
    input  logic [NREGS-1:0]  pend,
    input  logic              flag_pend,
    input  logic              use1,
    input  logic              use2,
    input  logic [REG_AW-1:0] src1,
    input  logic [REG_AW-1:0] src2,
    input  logic              wr1,
    input  logic              wr2,
    input  logic [REG_AW-1:0] dst1,
    input  logic [REG_AW-1:0] dst2,
    input  logic              is_cond,
    input  logic [FLAG_W-1:0] wr_flags,
    output logic              hazard
);

    logic raw;
    logic waw;
    logic flag_hz;

    always_comb begin
        raw     = (use1 && pend[src1]) || (use2 && pend[src2]);
        waw     = (wr1 && pend[dst1]) || (wr2 && pend[dst2]);
        flag_hz = (is_cond || (wr_flags != '0)) && flag_pend;
        hazard  = raw || waw || flag_hz;
    end

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: register/flag pending tracking, in-flight bound, flush drain.
// Optional macro ISSUE_RETIRE_BYPASS_EN lets same-cycle retirements clear hazards.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF,
    parameter int unsigned NREGS        = 32
) (
    input  logic                clk,
    input  logic                rst,
    issue_scoreboard_if.slave   bus,
    output logic [INFL_W-1:0]   inflight,
    output logic [15:0]         stall_cnt,
    output logic                sb_err
);

    localparam logic [INFL_W-1:0] MAX_INF = INFL_W'(MAX_INFLIGHT);

    sb_state_e         state_q, state_d;
    logic [NREGS-1:0]  pend_q, pend_d;
    logic              flag_pend_q, flag_pend_d;
    logic [INFL_W-1:0] inflight_q, inflight_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;
    logic              sb_err_q, sb_err_d;

    logic [NREGS-1:0]  clr_mask, set_mask, pend_view;
    logic              flag_clr, flag_view;
    logic              hazard, ready, issue, retire_err, retire_dec;

    always_comb begin
        clr_mask = '0;
        if (bus.wb_valid) begin
            if (bus.wb_we1) clr_mask[bus.wb_a1] = 1'b1;
            if (bus.wb_we2) clr_mask[bus.wb_a2] = 1'b1;
        end
    end

    assign flag_clr = bus.wb_valid && bus.wb_flags;

`ifdef ISSUE_RETIRE_BYPASS_EN
    assign pend_view = pend_q & ~clr_mask;
    assign flag_view = flag_pend_q && !flag_clr;
`else
    assign pend_view = pend_q;
    assign flag_view = flag_pend_q;
`endif

    sb_hazard_check #(.NREGS(NREGS)) u_hazard (
        .pend      (pend_view),
        .flag_pend (flag_view),
        .use1      (bus.dec_use1),
        .use2      (bus.dec_use2),
        .src1      (bus.dec_src1),
        .src2      (bus.dec_src2),
        .wr1       (bus.dec_wr1),
        .wr2       (bus.dec_wr2),
        .dst1      (bus.dec_dst1),
        .dst2      (bus.dec_dst2),
        .is_cond   (bus.dec_is_cond),
        .wr_flags  (bus.dec_wr_flags),
        .hazard    (hazard)
    );

    assign ready = (state_q == RUN) && !hazard && (inflight_q < MAX_INF) && !bus.flush;
    assign issue = bus.dec_valid && ready;

    always_comb begin
        set_mask = '0;
        if (issue) begin
            if (bus.dec_wr1) set_mask[bus.dec_dst1] = 1'b1;
            if (bus.dec_wr2) set_mask[bus.dec_dst2] = 1'b1;
        end
    end

    // Retirement errors are judged against registered state, before this cycle's issue sets bits.
    assign retire_err = bus.wb_valid &&
                        ((bus.wb_we1 && !pend_q[bus.wb_a1]) ||
                         (bus.wb_we2 && !pend_q[bus.wb_a2]) ||
                         (bus.wb_flags && !flag_pend_q) ||
                         (inflight_q == '0));
    assign retire_dec = bus.wb_valid && (inflight_q != '0);

    always_comb begin
        state_d     = state_q;
        pend_d      = (pend_q & ~clr_mask) | set_mask;
        flag_pend_d = (flag_pend_q && !flag_clr) || (issue && (bus.dec_wr_flags != '0));
        inflight_d  = inflight_q;
        stall_cnt_d = stall_cnt_q;
        sb_err_d    = sb_err_q || retire_err;

        unique case ({issue, retire_dec})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase

        if ((state_q == RUN) && bus.dec_valid && !ready && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;

        unique case (state_q)
            RUN:   if (bus.flush) state_d = DRAIN;
            DRAIN: if (((inflight_q == '0) && !bus.wb_valid) ||
                       (bus.wb_valid && (inflight_q == INFL_W'(1))))
                       state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            pend_q      <= '0;
            flag_pend_q <= 1'b0;
            inflight_q  <= '0;
            stall_cnt_q <= '0;
            sb_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            flag_pend_q <= flag_pend_d;
            inflight_q  <= inflight_d;
            stall_cnt_q <= stall_cnt_d;
            sb_err_q    <= sb_err_d;
        end
    end

    assign bus.dec_ready = ready;
    assign bus.ex_issue  = issue;
    assign inflight      = inflight_q;
    assign stall_cnt     = stall_cnt_q;
    assign sb_err        = sb_err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: scenario table, random traffic against a queue-based model, stall saturation.
module tb_issue_scoreboard;
    import issue_scoreboard_pkg::*;

`ifdef ISSUE_RETIRE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int MAXI = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  inflight;
    logic [15:0] stall_cnt;
    logic        sb_err;

    issue_scoreboard_if bus();

    issue_scoreboard #(.MAX_INFLIGHT(MAXI), .NREGS(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .inflight  (inflight),
        .stall_cnt (stall_cnt),
        .sb_err    (sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic dv; logic [4:0] s1, s2; logic u1, u2; logic [4:0] d1, d2; logic w1, w2;
        logic cond; logic [3:0] wf; logic wbv; logic [4:0] a1, a2; logic we1, we2;
        logic wbf; logic fl;
    } in_t;
    typedef struct { bit rst_first; in_t in; logic rdy; logic [2:0] inf; } vec_t;
    typedef struct { logic [4:0] d1, d2; logic w1, w2; logic f; } rec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mpend [32];
    bit   mflag;
    int   minf;
    bit   mdrain;
    int   mstall;
    bit   merr;
    rec_t q[$];
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input in_t v);
        bus.dec_valid = v.dv;  bus.dec_src1 = v.s1; bus.dec_src2 = v.s2;
        bus.dec_use1 = v.u1;   bus.dec_use2 = v.u2; bus.dec_dst1 = v.d1;
        bus.dec_dst2 = v.d2;   bus.dec_wr1 = v.w1;  bus.dec_wr2 = v.w2;
        bus.dec_is_cond = v.cond; bus.dec_wr_flags = v.wf;
        bus.wb_valid = v.wbv;  bus.wb_a1 = v.a1;    bus.wb_a2 = v.a2;
        bus.wb_we1 = v.we1;    bus.wb_we2 = v.we2;  bus.wb_flags = v.wbf;
        bus.flush = v.fl;
    endtask

    function automatic bit model_ready(input in_t v);
        bit p [32];
        bit f;
        bit hz;
        p = mpend;
        f = mflag;
        if (BYP && v.wbv) begin
            if (v.we1) p[v.a1] = 1'b0;
            if (v.we2) p[v.a2] = 1'b0;
            if (v.wbf) f = 1'b0;
        end
        hz = (v.u1 && p[v.s1]) || (v.u2 && p[v.s2]) || (v.w1 && p[v.d1]) ||
             (v.w2 && p[v.d2]) || ((v.cond || v.wf != 4'd0) && f);
        return !mdrain && !hz && (minf < MAXI) && !v.fl;
    endfunction

    task automatic model_step(input in_t v, input bit rdy);
        bit iss;
        int old;
        rec_t e;
        iss = v.dv && rdy;
        old = minf;
        if (v.wbv) begin
            if ((v.we1 && !mpend[v.a1]) || (v.we2 && !mpend[v.a2]) ||
                (v.wbf && !mflag) || old == 0) merr = 1'b1;
            if (v.we1) mpend[v.a1] = 1'b0;
            if (v.we2) mpend[v.a2] = 1'b0;
            if (v.wbf) mflag = 1'b0;
        end
        if (iss) begin
            if (v.w1) mpend[v.d1] = 1'b1;
            if (v.w2) mpend[v.d2] = 1'b1;
            if (v.wf != 4'd0) mflag = 1'b1;
            e.d1 = v.d1; e.d2 = v.d2; e.w1 = v.w1; e.w2 = v.w2; e.f = (v.wf != 4'd0);
            q.push_back(e);
        end
        if (!mdrain && v.dv && !rdy && mstall < 65535) mstall++;
        minf = old + (iss ? 1 : 0) - ((v.wbv && old > 0) ? 1 : 0);
        if (!mdrain) begin
            if (v.fl) mdrain = 1'b1;
        end else if ((old == 0 && !v.wbv) || (v.wbv && old == 1)) begin
            mdrain = 1'b0;
        end
    endtask

    // Called #1 after a rising edge; returns the sampled dec_ready.
    task automatic apply(input in_t v, output logic act_rdy);
        bit rdy;
        drive(v);
        #3;
        rdy = model_ready(v);
        act_rdy = bus.dec_ready;
        chk("dec_ready", bus.dec_ready, 32'(rdy));
        chk("ex_issue", bus.ex_issue, 32'(v.dv && rdy));
        @(posedge clk);
        model_step(v, rdy);
        #1;
        chk("inflight", inflight, minf);
        chk("stall_cnt", stall_cnt, mstall);
        chk("sb_err", sb_err, 32'(merr));
    endtask

    task automatic do_reset();
        in_t z;
        z = '{default: '0};
        drive(z);
        rst = 1'b0;
        #2;
        chk("rst_inflight", inflight, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_err", sb_err, 0);
        chk("rst_ready", bus.dec_ready, 1);
        chk("rst_issue", bus.ex_issue, 0);
        rst = 1'b1;
        foreach (mpend[i]) mpend[i] = 1'b0;
        mflag = 1'b0; minf = 0; mdrain = 1'b0; mstall = 0; merr = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input bit r, input logic dv, input logic [4:0] s1, input logic u1,
                                input logic [4:0] d1, input logic w1, input logic cond,
                                input logic [3:0] wf, input logic wbv, input logic [4:0] a1,
                                input logic we1, input logic wbf, input logic fl,
                                input logic rdy, input logic [2:0] inf);
        vec_t t;
        t.rst_first = r;
        t.in = '{default: '0};
        t.in.dv = dv; t.in.s1 = s1; t.in.u1 = u1; t.in.d1 = d1; t.in.w1 = w1;
        t.in.cond = cond; t.in.wf = wf; t.in.wbv = wbv; t.in.a1 = a1; t.in.we1 = we1;
        t.in.wbf = wbf; t.in.fl = fl;
        t.rdy = rdy; t.inf = inf;
        return t;
    endfunction

    task automatic run_range(input int lo, input int hi);
        logic r;
        for (int i = lo; i <= hi; i++) begin
            if (tbl[i].rst_first) do_reset();
            apply(tbl[i].in, r);
            chk($sformatf("vec%0d_ready", i), r, 32'(tbl[i].rdy));
            chk($sformatf("vec%0d_inflight", i), inflight, 32'(tbl[i].inf));
        end
    endtask

    initial begin
        in_t  v;
        rec_t e;
        logic r;

        // RAW on r3 (0-4)
        tbl.push_back(mk(1'b1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1));
        tbl.push_back(mk(1'b0, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
        tbl.push_back(mk(1'b0, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
        tbl.push_back(mk(1'b0, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 4'h0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, BYP, BYP ? 3'd1 : 3'd0));
        tbl.push_back(mk(1'b0, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, BYP ? 3'd2 : 3'd1));
        // in-flight limit (5-11)
        tbl.push_back(mk(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1));
        tbl.push_back(mk(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2));
        tbl.push_back(mk(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3));
        tbl.push_back(mk(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4));
        tbl.push_back(mk(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4));
        tbl.push_back(mk(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'h0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3));
        tbl.push_back(mk(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4));
        // flags (12-15)
        tbl.push_back(mk(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'hF, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1));
        tbl.push_back(mk(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
        tbl.push_back(mk(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 4'h0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, BYP, BYP ? 3'd1 : 3'd0));
        tbl.push_back(mk(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, BYP ? 3'd2 : 3'd1));
        // flush / drain (16-22)
        tbl.push_back(mk(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1));
        tbl.push_back(mk(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2));
        tbl.push_back(mk(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2));
        tbl.push_back(mk(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2));
        tbl.push_back(mk(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'h0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
        tbl.push_back(mk(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'h0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        tbl.push_back(mk(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1));
        // same-cycle issue/retire on r7 (23-26)
        tbl.push_back(mk(1'b1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1));
        tbl.push_back(mk(1'b0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 4'h0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, BYP, BYP ? 3'd1 : 3'd0));
        tbl.push_back(mk(1'b0, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, !BYP, 3'd1));
        tbl.push_back(mk(1'b0, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 4'h0, 1'b1, 5'd7, BYP, 1'b0, 1'b0, 1'b1, 3'd1));
        // bogus retirement (27-28)
        tbl.push_back(mk(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'h0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0));
        tbl.push_back(mk(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0));

        #1;
        do_reset();
        run_range(0, 4);
        chk("raw_stall_cycles", stall_cnt, BYP ? 32'd2 : 32'd3);
        run_range(5, 15);
        run_range(16, 22);
        chk("drain_stall_cycles", stall_cnt, 32'd1);
        run_range(23, 28);
        chk("err_sticky", sb_err, 32'd1);
        do_reset();

        // Random traffic; retirements come in issue order from the model's queue.
        for (int n = 0; n < 3000; n++) begin
            v = '{default: '0};
            v.dv   = ($urandom_range(0, 3) != 0);
            v.s1   = 5'($urandom_range(0, 7));
            v.s2   = 5'($urandom_range(0, 7));
            v.u1   = 1'($urandom_range(0, 1));
            v.u2   = 1'($urandom_range(0, 1));
            v.d1   = 5'($urandom_range(0, 7));
            v.d2   = 5'($urandom_range(0, 7));
            v.w1   = 1'($urandom_range(0, 1));
            v.w2   = 1'($urandom_range(0, 1));
            v.cond = ($urandom_range(0, 3) == 0);
            v.wf   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            v.fl   = ($urandom_range(0, 29) == 0);
            if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
                e = q.pop_front();
                v.wbv = 1'b1; v.a1 = e.d1; v.a2 = e.d2;
                v.we1 = e.w1; v.we2 = e.w2; v.wbf = e.f;
            end
            apply(v, r);
        end

        // Hold a RAW stall long enough to saturate the stall counter.
        do_reset();
        v = '{default: '0};
        v.dv = 1'b1; v.d1 = 5'd1; v.w1 = 1'b1;
        apply(v, r);
        v = '{default: '0};
        v.dv = 1'b1; v.s1 = 5'd1; v.u1 = 1'b1;
        drive(v);
        repeat (65540) @(posedge clk);
        #1;
        chk("stall_saturate", stall_cnt, 32'hFFFF);
        chk("stall_saturate_ready", bus.dec_ready, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

In-order issue controller between decode and the execute stage. It tracks pending register writes (up to two per instruction, matching the dual-result ALU) and pending status-flag writes in a scoreboard, and stalls decode on RAW/WAW hazards. Writeback retirements clear the tracked state. It also bounds in-flight instructions and drains the pipe on a front-end flush.

## Interface
Parameters:
- MAX_INFLIGHT, 4: maximum issued-but-unretired instructions (2..7).
- NREGS, 32: scoreboard entries; register addresses are 5 bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- dec_valid  in  1  decode presents an instruction.
- dec_ready  out  1  controller accepts it this cycle.
- dec_src1, dec_src2  in  5  source register addresses.
- dec_use1, dec_use2  in  1  source is actually read.
- dec_dst1, dec_dst2  in  5  destination addresses, taken from r1/r2 results.
- dec_wr1, dec_wr2  in  1  destination is written.
- dec_is_cond  in  1  instruction reads status flags.
- dec_wr_flags  in  4  n/z/c/v write mask.
- wb_valid  in  1  writeback retires one instruction.
- wb_a1, wb_a2  in  5  retired destination addresses.
- wb_we1, wb_we2  in  1  retired destination valid.
- wb_flags  in  1  retiring instruction wrote flags.
- flush  in  1  front-end flush request (1-cycle pulse).
- ex_issue  out  1  load enable for the execute input registers; equals dec_valid && dec_ready.
- inflight  out  3  current in-flight count.
- stall_cnt  out  16  saturating count of cycles with dec_valid && !dec_ready.
- sb_err  out  1  sticky: a retirement referenced a non-pending entry, or the in-flight count would underflow.

## Operation
- State: pend[NREGS-1:0], flag_pend, inflight counter, FSM {RUN, DRAIN}.
- Hazard is true if any of the following holds:
  - (dec_use1 && pend[dec_src1]) or (dec_use2 && pend[dec_src2]): RAW.
  - (dec_wr1 && pend[dec_dst1]) or (dec_wr2 && pend[dec_dst2]): WAW.
  - (dec_is_cond || dec_wr_flags != 0) && flag_pend.
- dec_ready = (state == RUN) && !hazard && inflight < MAX_INFLIGHT && !flush.
- On issue:
  - Set pend[dec_dst1] if dec_wr1; set pend[dec_dst2] if dec_wr2.
  - Set flag_pend if dec_wr_flags != 0.
  - inflight +1.
- dec_dst1 == dec_dst2 with both written: one bit set; no error.
- On wb_valid:
  - Clear pend[wb_a1] if wb_we1; clear pend[wb_a2] if wb_we2; clear flag_pend if wb_flags.
  - inflight −1.
  - Set sb_err if any cleared entry was already 0, or if inflight was 0 (counter holds at 0).
- Issue and retire in the same cycle:
  - inflight is unchanged.
  - For a bit both set and cleared, set wins (the new write is pending).
- FSM:
  - RUN → DRAIN on flush.
  - DRAIN → RUN when inflight == 0 and no wb_valid that cycle, or on the cycle the last retirement lands. Retirements continue to be processed in DRAIN.
  - Flush in DRAIN is ignored.
- stall_cnt increments only in RUN and saturates at 0xFFFF.

## Timing
- Reset (rst low, asynchronous): pend = 0, flag_pend = 0, inflight = 0, state = RUN, stall_cnt = 0, sb_err = 0.
- Reset outputs: dec_ready = 1 only if dec_valid-independent conditions hold; ex_issue = 0.
- Reset mid-operation discards all pending state; no retirement is expected afterwards.
- dec_ready and ex_issue are combinational from registered state and current decode/flush inputs. There is no combinational path from the wb_* inputs unless the bypass macro below is defined.
- Hazard-free issue latency: 0 cycles. The execute registers load on the same edge that sets the scoreboard.
- A dependent instruction becomes issuable the cycle after its producer's wb_valid edge (without the bypass).

## Configuration
- ISSUE_RETIRE_BYPASS_EN defined: the hazard check uses pend & ~retire_mask, with the same-cycle wb_* clears applied combinationally, so a dependent instruction issues in the same cycle as the retirement.
- Without the macro: the hazard check uses registered pend/flag_pend only, giving a 1-cycle bubble.

## Structure
- Shared package holds:
  - REG_AW = 5.
  - FLAG_W = 4.
  - FSM state encoding (RUN = 1'b0, DRAIN = 1'b1).
  - MAX_INFLIGHT default.
- Natural sub-module: sb_hazard_check (combinational hazard evaluation from pend, flag_pend and decode fields), instantiated once.

## Test plan
- Reset then issue dst1 = 3 (wr1), followed by an instruction with src1 = 3 (use1) → dec_ready = 0 until wb_valid with wb_a1 = 3. Without the bypass it issues 1 cycle after; with ISSUE_RETIRE_BYPASS_EN it issues the same cycle. stall_cnt counts the stall cycles.
- Issue 4 independent instructions with no retirements → inflight = 4 and dec_ready = 0. One retirement → inflight = 3 and the next instruction issues.
- Issue with dec_wr_flags = 4'b1111, then an instruction with dec_is_cond = 1 → stalled until wb_flags = 1.
- With inflight = 2, pulse flush → state DRAIN and dec_ready = 0. Two retirements → RUN on the cycle inflight reaches 0, and issue resumes.
- Same-cycle issue of dst1 = 7 and retire of wb_a1 = 7 (previously pending) → pend[7] remains 1 and inflight is unchanged.
- wb_valid with wb_a1 = 9, wb_we1 = 1 while pend[9] = 0 → sb_err = 1 and stays 1 until rst.
